mux2to1_rr_arb: RTL and testbench
=================================

// Module: mux2to1_rr_arb
// PURPOSE
//  Two-channel round-robin arbiter and output register stage upstream of mux2to1 select logic.
//  Grants one of two requesting sources and drives sel (0 = in0, 1 = in1).
//  Captures the selected word into a registered output with a valid/ready handshake to the consumer.
//  Bounds each grant with a burst limit so neither channel starves the other.
// PARAMETERS
//  WIDTH      8   data width of in0, in1, out
//  MAX_BURST  4   max consecutive transfers per grant while the other channel requests (>=1)
//  CNT_W      3   burst counter width; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  rst_n    in   1      synchronous reset, active-low
//  req0     in   1      channel 0 has data; held until ack0
//  in0      in   WIDTH  channel 0 data, stable while req0 high
//  ack0     out  1      channel 0 word accepted this cycle (combinational)
//  req1     in   1      channel 1 has data; held until ack1
//  in1      in   WIDTH  channel 1 data, stable while req1 high
//  ack1     out  1      channel 1 word accepted this cycle (combinational)
//  sel      out  1      current grant: 0 = ch0 (also in IDLE), 1 = ch1
//  out      out  WIDTH  registered selected data
//  out_vld  out  1      out holds a word not yet taken
//  out_rdy  in   1      consumer takes out when out_vld & out_rdy
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, cnt=0, last=1 (ch0 wins first tie), out=0, out_vld=0.
//  Acks and sel are low/0 while in IDLE and after reset. Reset mid-operation discards the held word.
//  Definitions:
//   space  = !out_vld | out_rdy
//   ack0   = (state==GNT0) & req0 & space
//   ack1   = (state==GNT1) & req1 & space
//   sel    = (state==GNT1)
//  Datapath:
//   On ack_i: out<=in_i, out_vld<=1.
//   Otherwise, if out_rdy: out_vld<=0 (out keeps its value).
//   Latency: req_i sampled in a grant cycle -> out_vld the next cycle. Sustains 1 word/cycle.
//  FSM states: IDLE, GNT0, GNT1.
//   IDLE:
//    -> GNT0 if req0 & (!req1 | last==1)
//    -> GNT1 if req1 & (!req0 | last==0)
//    No ack is issued in IDLE, so the first transfer costs 1 cycle.
//   GNT0 (GNT1 symmetric):
//    - Each ack0: cnt<=cnt+1, last<=0.
//    - done = !req0 | (ack0 & cnt==MAX_BURST-1).
//    - On done:
//      - req1 high -> GNT1, cnt<=0.
//      - else if req0 still high -> stay GNT0, cnt<=0 (burst restarts, no starvation possible).
//      - else -> IDLE, cnt<=0.
//    - Backpressure (space=0): no ack, cnt holds, state holds, even if the other channel requests.
//  Simultaneous events:
//   - out_rdy and ack in the same cycle: consumer takes the old word, new word loads, out_vld stays 1.
//   - req drop and burst limit in the same cycle: handled as done.
//  Grant switch occurs at the edge; the new channel can be acked in the very next cycle.
// TESTING
//  1 Reset: rst_n=0 two cycles with req0=req1=1 -> out_vld=0, out=0, ack0=ack1=0, sel=0; after release ch0 granted first.
//  2 Single channel: req0=1 held, in0=8'hA5, out_rdy=1 -> IDLE->GNT0, ack0 every cycle, out=A5 one cycle after each ack, cnt wraps after 4, no gap.
//  3 Fairness: req0=req1=1 continuous, out_rdy=1 -> 4 words from ch0, sel flips to 1, 4 words from ch1, repeat; sel toggles every 4 transfers.
//  4 Backpressure: out_vld=1, out_rdy=0 for 5 cycles with both reqs high -> no ack, out stable, cnt frozen; out_rdy=1 -> ack resumes same cycle.
//  5 Early drop: GNT0 with cnt=1, req0 falls, req1=1 -> next cycle sel=1, cnt=0, ack1 asserted.
//  6 Mid-burst reset: rst_n=0 while out_vld=1 in GNT1 -> next cycle out_vld=0, state IDLE, last=1.

Source files
------------

// File: rtl/mux2to1_rr_arb.sv
// Two-channel round-robin arbiter with a burst limit, feeding a registered
// output stage with a valid/ready handshake to the consumer.
module mux2to1_rr_arb #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             ack1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  input  logic             out_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             space;
  logic             done0, done1;

  // The output register can accept a word if empty or being drained this cycle.
  assign space = !vld_q || out_rdy;
  assign ack0  = (state_q == GNT0) && req0 && space;
  assign ack1  = (state_q == GNT1) && req1 && space;
  assign sel   = (state_q == GNT1);
  assign done0 = !req0 || (ack0 && (cnt_q == CNT_LAST));
  assign done1 = !req1 || (ack1 && (cnt_q == CNT_LAST));

  assign out     = out_q;
  assign out_vld = vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // last_q == 1 means ch1 was served most recently, so ch0 wins a tie.
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (ack0) begin
          cnt_d  = cnt_q + CNT_W'(1);
          last_d = 1'b0;
        end
        if (done0) begin
          cnt_d = '0;
          if (req1) begin
            state_d = GNT1;
          end else if (req0) begin
            state_d = GNT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT1: begin
        if (ack1) begin
          cnt_d  = cnt_q + CNT_W'(1);
          last_d = 1'b1;
        end
        if (done1) begin
          cnt_d = '0;
          if (req0) begin
            state_d = GNT0;
          end else if (req1) begin
            state_d = GNT1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    vld_d = vld_q;
    if (ack0) begin
      out_d = in0;
      vld_d = 1'b1;
    end else if (ack1) begin
      out_d = in1;
      vld_d = 1'b1;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_rr_arb.sv
// Directed bench for mux2to1_rr_arb: reset, bursts, fairness, backpressure,
// early request drop, mid-burst reset and idle re-arbitration.
module tb_mux2to1_rr_arb;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] in0, in1;
  logic       ack0, ack1, sel;
  logic [7:0] out;
  logic       out_vld;
  logic       out_rdy;

  int unsigned total;
  int unsigned bad;

  mux2to1_rr_arb #(
    .WIDTH    (8),
    .MAX_BURST(4),
    .CNT_W    (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .in0    (in0),
    .ack0   (ack0),
    .req1   (req1),
    .in1    (in1),
    .ack1   (ack1),
    .sel    (sel),
    .out    (out),
    .out_vld(out_vld),
    .out_rdy(out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are changed just after a rising edge; checks happen 1ns later.
  task automatic look(input string tag, input logic e_sel, input logic e_a0,
                      input logic e_a1, input logic [7:0] e_out, input logic e_vld);
    #1;
    chk({tag, ".sel"},     32'(sel),     32'(e_sel));
    chk({tag, ".ack0"},    32'(ack0),    32'(e_a0));
    chk({tag, ".ack1"},    32'(ack1),    32'(e_a1));
    chk({tag, ".out"},     32'(out),     32'(e_out));
    chk({tag, ".out_vld"}, 32'(out_vld), 32'(e_vld));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    req0    = 1'b1;
    req1    = 1'b1;
    in0     = 8'hA5;
    in1     = 8'h3C;
    out_rdy = 1'b1;

    // Reset held two cycles with both channels requesting
    step();
    step();
    look("rst", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    look("idle0", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();  // IDLE -> GNT0 (tie goes to ch0)

    // Fairness: both requesting, 4 words each side
    in0 = 8'h01; look("f0", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(); in0 = 8'h02; look("f1", 1'b0, 1'b1, 1'b0, 8'h01, 1'b1);
    step(); in0 = 8'h03; look("f2", 1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
    step(); in0 = 8'h04; look("f3", 1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
    step(); in1 = 8'h81; look("f4", 1'b1, 1'b0, 1'b1, 8'h04, 1'b1);
    step(); in1 = 8'h82; look("f5", 1'b1, 1'b0, 1'b1, 8'h81, 1'b1);
    step(); in1 = 8'h83; look("f6", 1'b1, 1'b0, 1'b1, 8'h82, 1'b1);
    step(); in1 = 8'h84; look("f7", 1'b1, 1'b0, 1'b1, 8'h83, 1'b1);
    step(); in0 = 8'h05; look("f8", 1'b0, 1'b1, 1'b0, 8'h84, 1'b1);
    step();  // ch0 word 05 taken, cnt=1

    // Backpressure: five stalled cycles, then release
    out_rdy = 1'b0;
    in0     = 8'h06;
    look("bp0", 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      look($sformatf("bp%0d", i + 1), 1'b0, 1'b0, 1'b0, 8'h05, 1'b1);
    end
    out_rdy = 1'b1;
    look("bprel", 1'b0, 1'b1, 1'b0, 8'h05, 1'b1);
    step(); in0 = 8'h07; look("bp_c2", 1'b0, 1'b1, 1'b0, 8'h06, 1'b1);
    step(); in0 = 8'h08; look("bp_c3", 1'b0, 1'b1, 1'b0, 8'h07, 1'b1);
    step(); in1 = 8'h85; look("bp_sw", 1'b1, 1'b0, 1'b1, 8'h08, 1'b1);

    // Finish ch1 burst to reach GNT0 with cnt=0
    step(); in1 = 8'h86; look("g1a", 1'b1, 1'b0, 1'b1, 8'h85, 1'b1);
    step(); in1 = 8'h87; look("g1b", 1'b1, 1'b0, 1'b1, 8'h86, 1'b1);
    step(); in1 = 8'h88; look("g1c", 1'b1, 1'b0, 1'b1, 8'h87, 1'b1);
    step(); in0 = 8'h09; look("g1d", 1'b0, 1'b1, 1'b0, 8'h88, 1'b1);
    step();  // ch0 word 09 taken, cnt=1

    // Early drop of req0 mid-burst hands the grant to ch1 with a fresh count
    req0 = 1'b0;
    look("drop0", 1'b0, 1'b0, 1'b0, 8'h09, 1'b1);
    step(); in1 = 8'h89; req0 = 1'b1; in0 = 8'h0A;
    look("drop1", 1'b1, 1'b0, 1'b1, 8'h09, 1'b0);
    step(); in1 = 8'h8A; look("drop2", 1'b1, 1'b0, 1'b1, 8'h89, 1'b1);
    step(); in1 = 8'h8B; look("drop3", 1'b1, 1'b0, 1'b1, 8'h8A, 1'b1);

    // Mid-burst reset in GNT1 with a held word
    rst_n = 1'b0;
    step();
    look("mrst", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    look("mrst_arb", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Single channel: continuous ch0 stream with no gap across burst wrap
    req1 = 1'b0;
    in0  = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      step();
      look($sformatf("single%0d", i), 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
    end

    // Drop req0 -> IDLE, then ch1 alone gets the grant after one idle cycle
    req0 = 1'b0;
    look("toidle0", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1);
    step();
    look("toidle1", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    req1 = 1'b1;
    in1  = 8'hC3;
    look("idle_req1", 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    step();
    look("gnt1", 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    step();
    req1 = 1'b0;
    look("gnt1_out", 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
